// File: rtl/mpsoc_sysid_pkg.sv
// Shared types and constants for the system-ID probe.
// The state enum is also exported on the probe's debug port.
package mpsoc_sysid_pkg;

   localparam int SYSID_DATA_W = 32;
   localparam int SYSID_ID_OFS = 0;
   localparam int SYSID_TS_OFS = 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ID_REQ  = 3'd1,
      ID_WAIT = 3'd2,
      TS_REQ  = 3'd3,
      TS_WAIT = 3'd4,
      FINISH  = 3'd5,
      ABORT   = 3'd6
   } sysid_state_t;

   // True while a read is in flight (request or response phase).
   function automatic logic is_read_phase(input sysid_state_t s);
      return (s == ID_REQ) || (s == ID_WAIT) || (s == TS_REQ) || (s == TS_WAIT);
   endfunction

   // True while the probe is presenting a read request on the bus.
   function automatic logic is_req_phase(input sysid_state_t s);
      return (s == ID_REQ) || (s == TS_REQ);
   endfunction

endpackage

// File: rtl/mpsoc_sysid_probe_if.sv
// Avalon-MM read-only bus between the system-ID probe (master) and the
// system-ID slave.
//
// Handshake: a request is accepted in the cycle where avm_read=1 and
// avm_waitrequest=0; until then the master holds avm_read and avm_address
// stable. Read data is valid only in a cycle with avm_readdatavalid=1, which
// may coincide with the acceptance cycle (zero latency) or come later.
interface mpsoc_sysid_probe_if #(
   parameter int ADDR_W = 1
);
   import mpsoc_sysid_pkg::*;

   logic [ADDR_W-1:0]       avm_address;
   logic                    avm_read;
   logic                    avm_waitrequest;
   logic [SYSID_DATA_W-1:0] avm_readdata;
   logic                    avm_readdatavalid;

   modport master (
      output avm_address,
      output avm_read,
      input  avm_waitrequest,
      input  avm_readdata,
      input  avm_readdatavalid
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      output avm_waitrequest,
      output avm_readdata,
      output avm_readdatavalid
   );

endinterface

// File: rtl/mpsoc_sysid_timeout_ctr.sv
// Per-read watchdog for the system-ID probe. The count restarts on load,
// advances while enable is high and saturates at TIMEOUT_CYC-1; expire is
// raised in every enabled cycle spent at that final value.
module mpsoc_sysid_timeout_ctr #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   input  logic enable,
   output logic expire
);

   localparam int               CNT_W = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] count;

   // Restart on load (load wins over enable), otherwise count up to LAST.
   always_ff @(posedge clock) begin
      if (reset || load) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   assign expire = enable && (count == LAST);

endmodule

// File: rtl/mpsoc_sysid_probe.sv
// System-ID probe: on a start pulse, reads the ID word and the timestamp
// word from an Avalon-MM system-ID slave, compares them against build-time
// values and reports pass/fail with a one-cycle done pulse.
//
// Optional feature macro: SYSID_PROBE_TIMEOUT_EN
//   defined   - each read is guarded by a TIMEOUT_CYC watchdog; expiry
//               aborts the probe with timeout=1.
//   undefined - no watchdog; the probe waits for the slave indefinitely
//               and timeout stays 0.
module mpsoc_sysid_probe
   import mpsoc_sysid_pkg::*;
#(
   parameter int                      ADDR_W      = 1,
   parameter int                      BASE_WORD   = 0,
   parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID = 32'h694C_2BC4,
   parameter logic [SYSID_DATA_W-1:0] EXPECTED_TS = 32'h0,
   parameter int                      CHECK_TS    = 1,
   parameter int                      TIMEOUT_CYC = 1024
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   mpsoc_sysid_probe_if.master     avm,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic                    timeout,
   output logic [SYSID_DATA_W-1:0] id_value,
   output logic [SYSID_DATA_W-1:0] ts_value,
   output sysid_state_t            dbg_state
);

   // The watchdog needs at least a request cycle and a response cycle.
   if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("mpsoc_sysid_probe: TIMEOUT_CYC must be at least 2");
   end

   localparam logic [ADDR_W-1:0] ID_ADDR = ADDR_W'(BASE_WORD + SYSID_ID_OFS);
   localparam logic [ADDR_W-1:0] TS_ADDR = ADDR_W'(BASE_WORD + SYSID_TS_OFS);

   sysid_state_t state;
   sysid_state_t state_next;

   logic accept;     // request handed to the slave this cycle
   logic rsp;        // response strobe from the slave
   logic expire;     // watchdog ran out for the current read
   logic id_cap;
   logic ts_cap;
   logic start_go;
   logic finish_go;
   logic abort_go;
   logic id_match;
   logic ts_match;

   // Bus outputs are decoded straight from the state, so a reset drops
   // avm_read on the very next edge and the address can never glitch
   // while a request is stalled.
   assign avm.avm_read    = is_req_phase(state);
   assign avm.avm_address = ((state == TS_REQ) || (state == TS_WAIT)) ? TS_ADDR : ID_ADDR;

   assign accept    = avm.avm_read && !avm.avm_waitrequest;
   assign rsp       = avm.avm_readdatavalid;
   assign dbg_state = state;

   assign id_match = (id_value == EXPECTED_ID);
   assign ts_match = (CHECK_TS == 0) || (ts_value == EXPECTED_TS);

`ifdef SYSID_PROBE_TIMEOUT_EN
   logic ctr_load;
   logic ctr_en;
   logic timeout_q;

   // The count restarts on the edge that enters either request state, so
   // one budget covers the request and the wait phase of a single read.
   assign ctr_load = ((state_next == ID_REQ) && (state != ID_REQ)) ||
                     ((state_next == TS_REQ) && (state != TS_REQ));
   assign ctr_en   = is_read_phase(state);

   mpsoc_sysid_timeout_ctr #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout_ctr (
      .clock  (clock),
      .reset  (reset),
      .load   (ctr_load),
      .enable (ctr_en),
      .expire (expire)
   );

   // Timeout flag: cleared by a new probe, set by an abort, held otherwise.
   always_ff @(posedge clock) begin
      if (reset) begin
         timeout_q <= 1'b0;
      end else if (start_go) begin
         timeout_q <= 1'b0;
      end else if (abort_go) begin
         timeout_q <= 1'b1;
      end
   end

   assign timeout = timeout_q;
`else
   assign expire  = 1'b0;
   assign timeout = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and capture decode. A response always beats the watchdog
   // in the same cycle; a response outside an acceptance or wait cycle
   // falls through every branch and is ignored.
   always_comb begin
      state_next = state;
      id_cap     = 1'b0;
      ts_cap     = 1'b0;
      start_go   = 1'b0;
      finish_go  = 1'b0;
      abort_go   = 1'b0;
      case (state)
         IDLE: begin
            if (start && !busy) begin
               state_next = ID_REQ;
               start_go   = 1'b1;
            end
         end
         ID_REQ: begin
            if (accept && rsp) begin
               id_cap     = 1'b1;
               state_next = TS_REQ;
            end else if (expire) begin
               state_next = ABORT;
            end else if (accept) begin
               state_next = ID_WAIT;
            end
         end
         ID_WAIT: begin
            if (rsp) begin
               id_cap     = 1'b1;
               state_next = TS_REQ;
            end else if (expire) begin
               state_next = ABORT;
            end
         end
         TS_REQ: begin
            if (accept && rsp) begin
               ts_cap     = 1'b1;
               state_next = FINISH;
            end else if (expire) begin
               state_next = ABORT;
            end else if (accept) begin
               state_next = TS_WAIT;
            end
         end
         TS_WAIT: begin
            if (rsp) begin
               ts_cap     = 1'b1;
               state_next = FINISH;
            end else if (expire) begin
               state_next = ABORT;
            end
         end
         FINISH: begin
            finish_go  = 1'b1;
            state_next = IDLE;
         end
         ABORT: begin
            abort_go   = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Result and capture registers. busy stays high through the done cycle
   // so a start arriving together with done is ignored.
   always_ff @(posedge clock) begin
      if (reset) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         id_value <= '0;
         ts_value <= '0;
      end else begin
         done <= finish_go || abort_go;
         if (start_go) begin
            busy <= 1'b1;
         end else if (done) begin
            busy <= 1'b0;
         end
         if (id_cap) begin
            id_value <= avm.avm_readdata;
         end
         if (ts_cap) begin
            ts_value <= avm.avm_readdata;
         end
         if (start_go || abort_go) begin
            pass <= 1'b0;
         end else if (finish_go) begin
            pass <= id_match && ts_match;
         end
      end
   end

endmodule

// File: tb/tb_mpsoc_sysid_probe.sv
// Self-checking bench for mpsoc_sysid_probe. A behavioural slave answers
// reads with configurable stall and latency; the driver pushes expected
// bus addresses and probe results into queues, and a monitor compares
// them whenever the probe issues a read or pulses done.
// The watchdog scenario runs only when SYSID_PROBE_TIMEOUT_EN is defined.
module tb_mpsoc_sysid_probe;
   import mpsoc_sysid_pkg::*;

   localparam int          ADDR_W      = 1;
   localparam int          BASE_WORD   = 0;
   localparam logic [31:0] EXP_ID      = 32'h694C_2BC4;
   localparam logic [31:0] EXP_TS      = 32'h5F3A_0001;
   localparam int          CHECK_TS    = 1;
   localparam int          TIMEOUT_CYC = 16;

   localparam logic [ADDR_W-1:0] ID_ADDR = ADDR_W'(BASE_WORD);
   localparam logic [ADDR_W-1:0] TS_ADDR = ADDR_W'(BASE_WORD + 1);

   typedef struct {
      logic        pass;
      logic        timeout;
      logic [31:0] id;
      logic [31:0] ts;
      int          done_cyc;
   } exp_t;

   // ---------------- clock / reset ----------------
   logic         clock;
   logic         reset;
   logic         start;
   logic         busy;
   logic         done;
   logic         pass;
   logic         timeout;
   logic [31:0]  id_value;
   logic [31:0]  ts_value;
   sysid_state_t dbg_state;
   int           cyc = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   mpsoc_sysid_probe_if #(.ADDR_W(ADDR_W)) avm ();

   mpsoc_sysid_probe #(
      .ADDR_W      (ADDR_W),
      .BASE_WORD   (BASE_WORD),
      .EXPECTED_ID (EXP_ID),
      .EXPECTED_TS (EXP_TS),
      .CHECK_TS    (CHECK_TS),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .avm       (avm),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .timeout   (timeout),
      .id_value  (id_value),
      .ts_value  (ts_value),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   logic [ADDR_W-1:0] exp_addr_q[$];
   exp_t              exp_res_q[$];
   exp_t              mon_e;
   int                checks = 0;
   int                failures = 0;
   int                accepts = 0;
   int                exp_accepts = 0;
   logic [31:0]       m_id = '0;
   logic [31:0]       m_ts = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- slave model ----------------
   int          cfg_ws_id = 0;
   int          cfg_ws_ts = 0;
   int          cfg_lat = 1;
   logic [31:0] cfg_id = '0;
   logic [31:0] cfg_ts = '0;
   bit          cfg_mute = 1'b0;
   bit          cfg_spurious = 1'b0;
   bit          in_req = 1'b0;
   int          stall = 0;
   int          resp_cnt = 0;
   logic [31:0] resp_data = '0;

   // Drives the slave side a little after each edge, once the probe's
   // state-decoded outputs have settled for the new cycle.
   initial begin
      avm.avm_waitrequest   = 1'b0;
      avm.avm_readdatavalid = 1'b0;
      avm.avm_readdata      = '0;
      forever begin
         @(posedge clock);
         #2;
         avm.avm_readdatavalid = 1'b0;
         avm.avm_waitrequest   = 1'b0;
         avm.avm_readdata      = $urandom();
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               avm.avm_readdatavalid = 1'b1;
               avm.avm_readdata      = resp_data;
            end
         end else if (cfg_spurious && !avm.avm_read) begin
            avm.avm_readdatavalid = 1'b1;
            avm.avm_readdata      = 32'hDEAD_BEEF;
            cfg_spurious          = 1'b0;
         end
         if (!avm.avm_read) begin
            in_req = 1'b0;
         end else begin
            if (!in_req) begin
               in_req = 1'b1;
               stall  = (avm.avm_address == TS_ADDR) ? cfg_ws_ts : cfg_ws_id;
            end
            if (stall > 0) begin
               avm.avm_waitrequest = 1'b1;
               stall--;
            end else begin
               in_req = 1'b0;
               if (!cfg_mute) begin
                  resp_data = (avm.avm_address == TS_ADDR) ? cfg_ts : cfg_id;
                  if (cfg_lat == 0) begin
                     avm.avm_readdatavalid = 1'b1;
                     avm.avm_readdata      = resp_data;
                  end else begin
                     resp_cnt = cfg_lat;
                  end
               end
            end
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clock) begin
      if (!reset) begin
         if (avm.avm_read) begin
            if (!avm.avm_waitrequest) accepts++;
            if (exp_addr_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_read: address %0h with no read expected (cycle %0d)",
                        avm.avm_address, cyc);
            end else begin
               chk("rd_addr", 32'(avm.avm_address), 32'(exp_addr_q[0]));
               if (!avm.avm_waitrequest) void'(exp_addr_q.pop_front());
            end
         end
         if (done) begin
            if (exp_res_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: done=1 with no probe expected (cycle %0d)", cyc);
            end else begin
               mon_e = exp_res_q.pop_front();
               chk("pass", 32'(pass), 32'(mon_e.pass));
               chk("timeout", 32'(timeout), 32'(mon_e.timeout));
               chk("id_value", id_value, mon_e.id);
               chk("ts_value", ts_value, mon_e.ts);
               chk("done_cycle", cyc, mon_e.done_cyc);
               chk("busy_at_done", 32'(busy), 32'd1);
               chk("read_at_done", 32'(avm.avm_read), 32'd0);
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic run_probe(input logic [31:0] id, input logic [31:0] ts,
                            input int ws_id, input int ws_ts, input int lat,
                            input bit mute, input bit extra_start, input bit reset_mid);
      int   s;
      int   waited;
      exp_t e;
      cfg_id    = id;
      cfg_ts    = ts;
      cfg_ws_id = ws_id;
      cfg_ws_ts = ws_ts;
      cfg_lat   = lat;
      cfg_mute  = mute;
      @(negedge clock);
      s = cyc;
      exp_addr_q.push_back(ID_ADDR);
      exp_accepts++;
      if (mute) begin
         e.pass     = 1'b0;
         e.timeout  = 1'b1;
         e.id       = m_id;
         e.ts       = m_ts;
         e.done_cyc = s + TIMEOUT_CYC + 2;
      end else begin
         if (!reset_mid) begin
            exp_addr_q.push_back(TS_ADDR);
            exp_accepts++;
         end
         m_id       = id;
         m_ts       = ts;
         e.pass     = (id == EXP_ID) && ((CHECK_TS == 0) || (ts == EXP_TS));
         e.timeout  = 1'b0;
         e.id       = id;
         e.ts       = ts;
         // each read: stall cycles + acceptance cycle + response latency;
         // then one finishing cycle before the done pulse
         e.done_cyc = s + (ws_id + 1 + lat) + (ws_ts + 1 + lat) + 2;
      end
      if (!reset_mid) exp_res_q.push_back(e);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      if (reset_mid) begin
         @(negedge clock);
         reset = 1'b1;
         exp_addr_q.delete();
         exp_res_q.delete();
         m_id = '0;
         m_ts = '0;
         @(negedge clock);
         reset = 1'b0;
         repeat (4) @(negedge clock);
         chk("post_reset_id", id_value, m_id);
         chk("post_reset_ts", ts_value, m_ts);
         chk("post_reset_busy", 32'(busy), 32'd0);
         chk("post_reset_pass", 32'(pass), 32'd0);
         chk("post_reset_read", 32'(avm.avm_read), 32'd0);
         return;
      end
      if (extra_start) begin
         @(negedge clock);
         start = 1'b1;
         @(negedge clock);
         start = 1'b0;
      end
      waited = 0;
      while (!done && waited < 300) begin
         @(negedge clock);
         waited++;
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL done_wait: no done within 300 cycles (state %0d)", dbg_state);
      end else if (extra_start) begin
         start = 1'b1;
         @(negedge clock);
         start = 1'b0;
      end
      repeat (3) @(negedge clock);
      chk("busy_after_done", 32'(busy), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_id", id_value, 32'd0);
      chk("rst_ts", ts_value, 32'd0);
      chk("rst_read", 32'(avm.avm_read), 32'd0);
      chk("rst_addr", 32'(avm.avm_address), 32'(ID_ADDR));
      reset = 1'b0;
      repeat (2) @(negedge clock);

      run_probe(EXP_ID, EXP_TS, 0, 0, 1, 1'b0, 1'b0, 1'b0);       // matching build
      run_probe(32'h0000_0001, EXP_TS, 0, 0, 1, 1'b0, 1'b0, 1'b0); // wrong ID
      run_probe(EXP_ID, EXP_TS, 5, 0, 1, 1'b0, 1'b0, 1'b0);       // stalled ID request
      run_probe(EXP_ID, EXP_TS, 0, 0, 0, 1'b0, 1'b0, 1'b0);       // zero-latency responses
      run_probe(EXP_ID, 32'h0, 0, 2, 2, 1'b0, 1'b0, 1'b0);        // wrong timestamp

      cfg_spurious = 1'b1;                                           // stray response while idle
      repeat (4) @(negedge clock);
      chk("stray_rsp_id", id_value, m_id);
      chk("stray_rsp_ts", ts_value, m_ts);

      run_probe(EXP_ID, EXP_TS, 0, 0, 3, 1'b0, 1'b1, 1'b0);       // starts while busy
      run_probe(EXP_ID, EXP_TS, 0, 0, 3, 1'b0, 1'b0, 1'b1);       // reset in ID_WAIT
      run_probe(EXP_ID, EXP_TS, 1, 1, 1, 1'b0, 1'b0, 1'b0);       // recovers after reset

      for (int i = 0; i < 14; i++) begin
         logic [31:0] rid;
         logic [31:0] rts;
         rid = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom();
         rts = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom();
         run_probe(rid, rts, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'b0, 1'b0, 1'b0);
      end

`ifdef SYSID_PROBE_TIMEOUT_EN
      run_probe(EXP_ID, EXP_TS, 0, 0, 1, 1'b1, 1'b0, 1'b0);       // slave never answers
      cfg_mute = 1'b0;
      run_probe(EXP_ID, EXP_TS, 0, 0, 1, 1'b0, 1'b0, 1'b0);
`endif

      repeat (5) @(negedge clock);
      chk("accept_count", 32'(accepts), 32'(exp_accepts));
      chk("results_left", 32'(exp_res_q.size()), 32'd0);
      chk("reads_left", 32'(exp_addr_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
